snake_collision: RTL and testbench
==================================

# snake_collision

Collision checker for the snake game, reading the packed head/tail position vectors produced by the snake movement block. On each `start` strobe it snapshots the head, tail and food positions and reports wall, self and food hits. It scans the tail one segment per cycle through a small FSM, then pulses `done`. It sits between the movement block and game control (score/stop logic).

## Interface

Parameters:
- SEG_CNT, 15, number of tail segment slots in the packed vectors
- X_W, 7, bits per x coordinate
- Y_W, 6, bits per y coordinate
- X_MAX, 63, largest legal head x (grid columns 0..63)
- Y_MAX, 47, largest legal head y (grid rows 0..47)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request: new positions valid this cycle
- head_x  in  X_W  head column
- head_y  in  Y_W  head row
- tail_x  in  SEG_CNT*X_W  packed tail columns; segment i at [i*X_W +: X_W], segment 0 = newest
- tail_y  in  SEG_CNT*Y_W  packed tail rows, same packing
- length  in  4  active tail segments, 0..SEG_CNT
- food_x  in  X_W  food column
- food_y  in  Y_W  food row
- busy  out  1  high while a check is in progress
- done  out  1  one-cycle pulse: result flags valid
- wall_hit  out  1  head outside grid
- self_hit  out  1  head equals an active tail segment
- food_hit  out  1  head equals food
- hit_idx  out  4  index of first matching tail segment (0 if none)

## Operation

- FSM states: IDLE, SCAN, REPORT.
- IDLE: `start`=1 → latch head, tail, length, food into snapshot registers; clear all flags and hit_idx; busy=1; go to SCAN. If latched length is 0, go directly to REPORT instead.
- Length above SEG_CNT clamps to SEG_CNT at latch time.
- wall_hit = (head_x > X_MAX) or (head_y > Y_MAX). Computed from the snapshot and registered in the latch cycle. Underflow (0−1 = all ones) is therefore a wall hit.
- food_hit = snapshot head equals snapshot food. Registered in the latch cycle.
- SCAN:
  - Counter i starts at 0 and compares segment i against the snapshot head each cycle.
  - On a match: self_hit=1, hit_idx=i, go to REPORT. The scan stops at the first match.
  - If i = length−1 with no match, go to REPORT.
- REPORT: done=1 for one cycle; busy=0; go to IDLE.
- Flags and hit_idx hold after REPORT until the next accepted `start`.
- Segments at index ≥ length are never compared. Stale (0,0) entries in unused slots cause no false hit.
- `start` while busy is ignored; no queuing.
- `start` in the REPORT cycle is ignored.

## Timing

- `start` is sampled in cycle 0.
- `done` is asserted in cycle n+1, where n is the number of segments examined:
  - n = length with no hit.
  - n = k+1 with a first hit at segment k.
  - n = 0 when length = 0, so `done` is in cycle 1.
- Worst case: `done` in cycle SEG_CNT+1 = 16.
- busy is high from cycle 1 through cycle n; it is low in the done cycle.
- Input ports may change freely after cycle 0.
- Reset, including mid-scan: next state IDLE. busy, done, wall_hit, self_hit, food_hit and hit_idx are all 0, and the snapshot registers are 0.

## Configuration

- SNAKE_COLLISION_FOOD_EN defined: food compare is built in and food_hit behaves as above.
- Not defined: no food comparator. food_hit is a constant 0; food_x and food_y remain as ports but are ignored.

## Structure

- Shared package snake_pkg holds:
  - X_W, Y_W, SEG_CNT, X_MAX, Y_MAX constants.
  - The one-hot direction codes used by the movement block.
  - The FSM state typedef (IDLE/SCAN/REPORT).
- One sub-module, snake_seg_mux: selects segment i (x,y) from the packed snapshot vectors. It is purely combinational.

## Test plan

- Head (32,24), length 3, tail (31,24),(30,24),(29,24), food (5,5), `start` → done in cycle 4; all flags 0.
- Head (30,24), length 5, segment 2 = (30,24) → done in cycle 4; self_hit=1, hit_idx=2; busy low in the done cycle.
- Head x=127 (left underflow), length 0 → done in cycle 1; wall_hit=1. Repeat with head_y=48 → wall_hit=1.
- Head = food = (10,10), length 0 → food_hit=1 when the macro is defined; food_hit=0 when it is not.
- Length 2, tail slots 2..14 all (0,0), head (0,0), segments 0..1 non-matching → self_hit=0. Length 15 with a match only at slot 14 → done in cycle 16, hit_idx=14.
- `start` again in cycles 2..3 of a running scan → ignored, result unchanged. Reset in cycle 3 → cycle 4 shows busy=0, done=0, all flags 0.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg -- definitions shared by the snake game blocks.
//   Grid geometry (coordinate widths, tail slot count, legal head range),
//   the one-hot direction codes produced by the movement block, and the
//   state type of the collision checker FSM.
package snake_pkg;

  localparam int X_W     = 7;   // bits per x coordinate
  localparam int Y_W     = 6;   // bits per y coordinate
  localparam int SEG_CNT = 15;  // tail segment slots in the packed vectors
  localparam int X_MAX   = 63;  // largest legal head column
  localparam int Y_MAX   = 47;  // largest legal head row
  localparam int IDX_W   = 4;   // width of a tail segment index / length

  // Movement direction, one-hot
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } col_state_t;

endpackage

// File: rtl/snake_seg_mux.sv
// snake_seg_mux -- picks one tail segment out of the packed tail vectors.
//   Purely combinational.
// Ports:
//   tail_x  in  SEG_CNT*X_W  packed columns, segment i at [i*X_W +: X_W]
//   tail_y  in  SEG_CNT*Y_W  packed rows, same packing
//   idx     in  IDX_W        segment to select
//   seg_x   out X_W          column of segment idx (0 when idx >= SEG_CNT)
//   seg_y   out Y_W          row of segment idx (0 when idx >= SEG_CNT)
module snake_seg_mux
  import snake_pkg::*;
#(
  parameter int SEG_CNT = snake_pkg::SEG_CNT,
  parameter int X_W     = snake_pkg::X_W,
  parameter int Y_W     = snake_pkg::Y_W
) (
  input  logic [SEG_CNT*X_W-1:0] tail_x,
  input  logic [SEG_CNT*Y_W-1:0] tail_y,
  input  logic [IDX_W-1:0]       idx,
  output logic [X_W-1:0]         seg_x,
  output logic [Y_W-1:0]         seg_y
);

  // Loop-based select keeps every slice in range even for idx = 15.
  always_comb begin
    seg_x = '0;
    seg_y = '0;
    for (int i = 0; i < SEG_CNT; i++) begin
      if (idx == IDX_W'(i)) begin
        seg_x = tail_x[i*X_W +: X_W];
        seg_y = tail_y[i*Y_W +: Y_W];
      end
    end
  end

endmodule

// File: rtl/snake_collision.sv
// snake_collision -- wall / self / food collision checker for the snake game.
//   On start the head, tail, length and food are snapshotted. Wall and food
//   hits are decided in that same cycle; the tail is then scanned one segment
//   per cycle, stopping at the first segment equal to the head, and done
//   pulses for one cycle. Result flags hold until the next accepted start.
// Build option:
//   SNAKE_COLLISION_FOOD_EN  defined: food comparator built, food_hit live.
//                            undefined: food_hit tied to 0, food_x/food_y unused.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              one-cycle request, inputs valid this cycle
//   head_x, head_y     head position
//   tail_x, tail_y     packed tail positions, segment 0 newest
//   length             active tail segments (values above SEG_CNT clamp)
//   food_x, food_y     food position
//   busy               high while the tail scan runs
//   done               one-cycle pulse, flags valid
//   wall_hit           head outside the grid
//   self_hit           head on an active tail segment
//   food_hit           head on the food
//   hit_idx            first matching tail segment (0 if none)
module snake_collision
  import snake_pkg::*;
#(
  parameter int SEG_CNT = snake_pkg::SEG_CNT,
  parameter int X_W     = snake_pkg::X_W,
  parameter int Y_W     = snake_pkg::Y_W,
  parameter int X_MAX   = snake_pkg::X_MAX,
  parameter int Y_MAX   = snake_pkg::Y_MAX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [X_W-1:0]         head_x,
  input  logic [Y_W-1:0]         head_y,
  input  logic [SEG_CNT*X_W-1:0] tail_x,
  input  logic [SEG_CNT*Y_W-1:0] tail_y,
  input  logic [3:0]             length,
  input  logic [X_W-1:0]         food_x,
  input  logic [Y_W-1:0]         food_y,
  output logic                   busy,
  output logic                   done,
  output logic                   wall_hit,
  output logic                   self_hit,
  output logic                   food_hit,
  output logic [3:0]             hit_idx
);

  localparam logic [X_W-1:0] X_LIM   = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM   = Y_W'(Y_MAX);
  localparam logic [3:0]     LEN_LIM = 4'(SEG_CNT);

  col_state_t state, state_nxt;

  logic [X_W-1:0]         snap_hx;
  logic [Y_W-1:0]         snap_hy;
  logic [SEG_CNT*X_W-1:0] snap_tx;
  logic [SEG_CNT*Y_W-1:0] snap_ty;
  logic [3:0]             snap_len;
  logic [3:0]             scan_idx;

  logic [3:0]     len_clamp;
  logic           wall_in;
  logic [X_W-1:0] seg_x;
  logic [Y_W-1:0] seg_y;
  logic           seg_match;
  logic           last_seg;

  // Out-of-range x includes the 0-1 underflow (all ones).
  assign len_clamp = (length > LEN_LIM) ? LEN_LIM : length;
  assign wall_in   = (head_x > X_LIM) || (head_y > Y_LIM);

  snake_seg_mux #(
    .SEG_CNT (SEG_CNT),
    .X_W     (X_W),
    .Y_W     (Y_W)
  ) u_seg_mux (
    .tail_x (snap_tx),
    .tail_y (snap_ty),
    .idx    (scan_idx),
    .seg_x  (seg_x),
    .seg_y  (seg_y)
  );

  assign seg_match = (seg_x == snap_hx) && (seg_y == snap_hy);
  // SCAN is only entered with snap_len >= 1, so the subtraction never wraps there.
  assign last_seg  = (scan_idx == (snap_len - 4'd1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len_clamp == 4'd0) ? REPORT : SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (seg_match || last_seg) begin
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      snap_hx  <= '0;
      snap_hy  <= '0;
      snap_tx  <= '0;
      snap_ty  <= '0;
      snap_len <= '0;
      scan_idx <= '0;
      wall_hit <= 1'b0;
      self_hit <= 1'b0;
      hit_idx  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            snap_hx  <= head_x;
            snap_hy  <= head_y;
            snap_tx  <= tail_x;
            snap_ty  <= tail_y;
            snap_len <= len_clamp;
            scan_idx <= '0;
            wall_hit <= wall_in;
            self_hit <= 1'b0;
            hit_idx  <= '0;
          end
        end
        SCAN: begin
          if (seg_match) begin
            self_hit <= 1'b1;
            hit_idx  <= scan_idx;
          end else begin
            scan_idx <= scan_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SNAKE_COLLISION_FOOD_EN
  logic [X_W-1:0] snap_fx;
  logic [Y_W-1:0] snap_fy;

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_fx  <= '0;
      snap_fy  <= '0;
      food_hit <= 1'b0;
    end else if ((state == IDLE) && start) begin
      snap_fx  <= food_x;
      snap_fy  <= food_y;
      food_hit <= (head_x == food_x) && (head_y == food_y);
    end
  end
`else
  logic unused_food;
  assign unused_food = ^{food_x, food_y};
  assign food_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_snake_collision.sv
module tb_snake_collision;
  localparam int SEG = 15;
  localparam int XW  = 7;
  localparam int YW  = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [XW-1:0]    head_x;
  logic [YW-1:0]    head_y;
  logic [SEG*XW-1:0] tail_x;
  logic [SEG*YW-1:0] tail_y;
  logic [3:0]       length;
  logic [XW-1:0]    food_x;
  logic [YW-1:0]    food_y;
  logic             busy, done, wall_hit, self_hit, food_hit;
  logic [3:0]       hit_idx;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SNAKE_COLLISION_FOOD_EN
  localparam int FOOD_ON = 1;
`else
  localparam int FOOD_ON = 0;
`endif

  snake_collision dut (
    .clk(clk), .reset(reset), .start(start),
    .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
    .length(length), .food_x(food_x), .food_y(food_y),
    .busy(busy), .done(done), .wall_hit(wall_hit), .self_hit(self_hit),
    .food_hit(food_hit), .hit_idx(hit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per request: n segments examined, done in cycle n+1, busy in 1..n.
  bit m_active;
  int m_cyc, m_n;
  int r_wall, r_food, r_self, r_idx;       // result of the current check
  int d_wall, d_food, d_self, d_idx;       // what the flag outputs should show

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_cyc = 0; m_n = 0;
      d_wall = 0; d_food = 0; d_self = 0; d_idx = 0;
    end else if (m_active) begin
      if (m_cyc == m_n + 1) m_active = 0;
      else m_cyc++;
      if (m_active && m_cyc == m_n + 1) begin
        d_self = r_self; d_idx = r_idx;
      end
    end else if (start) begin
      int len;
      len = (int'(length) > SEG) ? SEG : int'(length);
      m_n = len; r_self = 0; r_idx = 0;
      for (int k = 0; k < len; k++) begin
        if (int'(tail_x[k*XW +: XW]) == int'(head_x) &&
            int'(tail_y[k*YW +: YW]) == int'(head_y)) begin
          r_self = 1; r_idx = k; m_n = k + 1;
          break;
        end
      end
      r_wall = (int'(head_x) > 63 || int'(head_y) > 47) ? 1 : 0;
      r_food = (FOOD_ON == 1 && head_x == food_x && head_y == food_y) ? 1 : 0;
      m_active = 1; m_cyc = 1;
      d_wall = r_wall; d_food = r_food; d_self = 0; d_idx = 0;
      if (m_cyc == m_n + 1) begin
        d_self = r_self; d_idx = r_idx;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit mon_en = 0;
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      chk("mon_busy", int'(busy), (m_active && m_cyc >= 1 && m_cyc <= m_n) ? 1 : 0);
      chk("mon_done", int'(done), (m_active && m_cyc == m_n + 1) ? 1 : 0);
      chk("mon_wall", int'(wall_hit), d_wall);
      chk("mon_food", int'(food_hit), d_food);
      chk("mon_self", int'(self_hit), d_self);
      chk("mon_idx",  int'(hit_idx),  d_idx);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_tail();
    tail_x = '0;
    tail_y = '0;
  endtask

  task automatic set_seg(input int k, input int x, input int y);
    tail_x[k*XW +: XW] = XW'(x);
    tail_y[k*YW +: YW] = YW'(y);
  endtask

  // Issues start in cycle 0, counts cycles until done (bounded).
  task automatic run(input string nm, input int hx, input int hy, input int fx,
                     input int fy, input int len, input int e_cyc, input int e_wall,
                     input int e_self, input int e_food, input int e_idx);
    int c;
    c = 0;
    @(negedge clk);
    head_x = XW'(hx); head_y = YW'(hy);
    food_x = XW'(fx); food_y = YW'(fy);
    length = 4'(len);
    start  = 1'b1;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      c++;
    end while (!done && c < 40);
    chk({nm, "_done_cycle"}, c, e_cyc);
    chk({nm, "_busy_at_done"}, int'(busy), 0);
    chk({nm, "_wall"}, int'(wall_hit), e_wall);
    chk({nm, "_self"}, int'(self_hit), e_self);
    chk({nm, "_food"}, int'(food_hit), e_food);
    chk({nm, "_idx"},  int'(hit_idx),  e_idx);
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_hold_self"}, int'(self_hit), e_self);
  endtask

  initial begin
    int c;
    reset = 1'b1; start = 1'b0;
    head_x = '0; head_y = '0; food_x = '0; food_y = '0; length = '0;
    clear_tail();
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_flags", int'({wall_hit, self_hit, food_hit}), 0);
    chk("rst_idx", int'(hit_idx), 0);
    @(negedge clk);
    reset = 1'b0;

    // Straight snake, no hit
    clear_tail();
    set_seg(0, 31, 24); set_seg(1, 30, 24); set_seg(2, 29, 24);
    run("straight", 32, 24, 5, 5, 3, 4, 0, 0, 0, 0);

    // Self hit at segment 2
    clear_tail();
    set_seg(0, 31, 24); set_seg(1, 31, 25); set_seg(2, 30, 24);
    set_seg(3, 29, 24); set_seg(4, 28, 24);
    run("self2", 30, 24, 5, 5, 5, 4, 0, 1, 0, 2);

    // Wall hits with no tail
    clear_tail();
    run("wall_x", 127, 10, 5, 5, 0, 1, 1, 0, 0, 0);
    run("wall_y", 10, 48, 5, 5, 0, 1, 1, 0, 0, 0);
    run("edge_ok", 63, 47, 5, 5, 0, 1, 0, 0, 0, 0);

    // Food on head
    run("food", 10, 10, 10, 10, 0, 1, 0, 0, FOOD_ON, 0);

    // Stale (0,0) slots past length never match
    clear_tail();
    set_seg(0, 1, 1); set_seg(1, 2, 2);
    run("stale", 0, 0, 9, 9, 2, 3, 0, 0, 0, 0);

    // Full length, match only at the last slot
    clear_tail();
    for (int k = 0; k < SEG; k++) set_seg(k, k + 1, 5);
    run("full14", 15, 5, 9, 9, 15, 16, 0, 1, 0, 14);

    // start in cycles 2..3 of a running scan is ignored
    clear_tail();
    set_seg(0, 31, 24); set_seg(1, 30, 24); set_seg(2, 29, 24);
    @(negedge clk);
    head_x = 7'd32; head_y = 6'd24; length = 4'd3; start = 1'b1;
    c = 0;
    @(posedge clk); #1; start = 1'b0; c++;              // cycle 1
    @(posedge clk); #1; c++;                            // cycle 2
    head_x = 7'd31; start = 1'b1;                       // would hit seg 0
    @(posedge clk); #1; c++;                            // cycle 3
    @(posedge clk); #1; c++; start = 1'b0;              // cycle 4
    chk("ign_done", int'(done), 1);
    chk("ign_self", int'(self_hit), 0);
    @(posedge clk); #1;
    chk("ign_idle_busy", int'(busy), 0);
    repeat (2) @(posedge clk);

    // Reset mid-scan clears everything
    clear_tail();
    for (int k = 0; k < 5; k++) set_seg(k, 1, k);
    @(negedge clk);
    head_x = 7'd127; head_y = 6'd3; length = 4'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;                   // cycle 1
    chk("mid_wall_early", int'(wall_hit), 1);
    @(posedge clk); #1;                                 // cycle 2
    @(posedge clk); #1; reset = 1'b1;                   // cycle 3
    @(posedge clk); #1;                                 // cycle 4
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_flags", int'({wall_hit, self_hit, food_hit}), 0);
    chk("mid_rst_idx", int'(hit_idx), 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // Check after reset works normally
    clear_tail();
    set_seg(0, 4, 4);
    run("post_rst", 4, 4, 0, 0, 1, 2, 0, 1, 0, 0);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
